// File: rtl/serial_prbs_checker.sv
// Receive-side PRBS bit checker: self-synchronises to the incoming pattern,
// flags per-bit errors while locked and keeps saturating BER counters.
module serial_prbs_checker #(
    parameter int unsigned POLY_LENGTH   = 9,
    parameter int unsigned POLY_TAP      = 5,
    parameter int unsigned INV_PATTERN   = 1,
    parameter int unsigned LOCK_COUNT    = 32,
    parameter int unsigned WINDOW        = 64,
    parameter int unsigned UNLOCK_ERRORS = 8,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] bit_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [15:0]          lock_loss_cnt
);

    localparam int unsigned FILL_W  = $clog2(POLY_LENGTH + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WIN_W   = $clog2(WINDOW);
    localparam int unsigned WERR_MAX = (WINDOW > UNLOCK_ERRORS) ? WINDOW : UNLOCK_ERRORS;
    localparam int unsigned WERR_W  = $clog2(WERR_MAX + 1);
    localparam int unsigned LOSS_W  = 16;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [POLY_LENGTH-1:0] sr, sr_nxt;
    logic [FILL_W-1:0]      fill_cnt, fill_nxt;
    logic [MATCH_W-1:0]     match_cnt, match_nxt;
    logic [WIN_W-1:0]       window_cnt, window_nxt;
    logic [WERR_W-1:0]      win_err, win_err_nxt, win_err_sum;
    logic [CNT_WIDTH-1:0]   bit_cnt_nxt, err_cnt_nxt;
    logic [LOSS_W-1:0]      loss_nxt;
    logic                   err_pulse_nxt;
    logic                   d_bit, e_bit, bit_err;

    assign d_bit = serial_in ^ 1'(INV_PATTERN);
    assign e_bit = sr[POLY_LENGTH-1] ^ sr[POLY_TAP-1];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= SEARCH;
            sr            <= '0;
            fill_cnt      <= '0;
            match_cnt     <= '0;
            window_cnt    <= '0;
            win_err       <= '0;
            bit_cnt       <= '0;
            err_cnt       <= '0;
            lock_loss_cnt <= '0;
            err_pulse     <= 1'b0;
            locked        <= 1'b0;
        end else begin
            state         <= state_nxt;
            sr            <= sr_nxt;
            fill_cnt      <= fill_nxt;
            match_cnt     <= match_nxt;
            window_cnt    <= window_nxt;
            win_err       <= win_err_nxt;
            bit_cnt       <= bit_cnt_nxt;
            err_cnt       <= err_cnt_nxt;
            lock_loss_cnt <= loss_nxt;
            err_pulse     <= err_pulse_nxt;
            locked        <= (state_nxt == LOCKED);
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nxt     = state;
        sr_nxt        = sr;
        fill_nxt      = fill_cnt;
        match_nxt     = match_cnt;
        window_nxt    = window_cnt;
        win_err_nxt   = win_err;
        bit_cnt_nxt   = bit_cnt;
        err_cnt_nxt   = err_cnt;
        loss_nxt      = lock_loss_cnt;
        err_pulse_nxt = 1'b0;
        bit_err       = 1'b0;
        win_err_sum   = win_err;

        case (state)
            SEARCH: begin
                sr_nxt = {sr[POLY_LENGTH-2:0], d_bit};
                if (fill_cnt != FILL_W'(POLY_LENGTH)) begin
                    fill_nxt = fill_cnt + FILL_W'(1);
                end else if ((d_bit == e_bit) && (sr != '0)) begin
                    if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                        state_nxt   = LOCKED;
                        match_nxt   = '0;
                        window_nxt  = '0;
                        win_err_nxt = '0;
                    end else begin
                        match_nxt = match_cnt + MATCH_W'(1);
                    end
                end else begin
                    match_nxt = '0;
                end
            end
            LOCKED: begin
                // Reference free-runs on its own prediction so line errors stay out of it
                sr_nxt        = {sr[POLY_LENGTH-2:0], e_bit};
                bit_err       = d_bit ^ e_bit;
                err_pulse_nxt = bit_err;
                win_err_sum   = win_err + WERR_W'(bit_err);
                if (bit_cnt != '1) bit_cnt_nxt = bit_cnt + CNT_WIDTH'(1);
                if (bit_err && (err_cnt != '1)) err_cnt_nxt = err_cnt + CNT_WIDTH'(1);
                if (window_cnt == WIN_W'(WINDOW - 1)) begin
                    window_nxt  = '0;
                    win_err_nxt = '0;
                    if (win_err_sum >= WERR_W'(UNLOCK_ERRORS)) begin
                        state_nxt = SEARCH;
                        fill_nxt  = '0;
                        match_nxt = '0;
                        if (lock_loss_cnt != '1) loss_nxt = lock_loss_cnt + LOSS_W'(1);
                    end
                end else begin
                    window_nxt  = window_cnt + WIN_W'(1);
                    win_err_nxt = win_err_sum;
                end
            end
            default: state_nxt = SEARCH;
        endcase

        // clear wins over any same-cycle increment
        if (clear) begin
            bit_cnt_nxt = '0;
            err_cnt_nxt = '0;
            loss_nxt    = '0;
        end
    end

endmodule
